// File: rtl/lstm_defs_pkg.sv
// Shared definitions for the LSTM activation memory sequencers.
// Holds the memory address width, FSM encodings and the stream beat record.
package lstm_defs_pkg;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned ACT_W      = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = 2;
    localparam int unsigned FIFO_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic             last;
        logic [ACT_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/act_fifo.sv
// Four-entry synchronous FIFO holding {last, data} stream beats.
// Registered head output; push/pop may occur in the same cycle.
module act_fifo
    import lstm_defs_pkg::*;
#(
    parameter int unsigned W = ACT_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  empty
);

    logic [W-1:0]          mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q;
    logic [FIFO_PTR_W-1:0] rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  do_push_c;
    logic                  do_pop_c;

    // Guard against misuse even though the reader's credit rule prevents it
    assign do_push_c = push && (count_q != FIFO_CNT_W'(FIFO_DEPTH));
    assign do_pop_c  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
                2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/act_stream_reader.sv
// Walks memory port B across one timestep of activations and turns the
// one-cycle synchronous read latency into a ready/valid stream with last flag.
module act_stream_reader
    import lstm_defs_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM      = 53,
    parameter int unsigned TIMESTEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] t_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  o_b,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam logic [ADDR_W-1:0] LAST_N    = ADDR_W'(NUM - 1);
    localparam logic [ADDR_W:0]   T_LIMIT   = (ADDR_W + 1)'(TIMESTEP);
    localparam logic [ADDR_W-1:0] NUM_A     = ADDR_W'(NUM);
    localparam logic              SINGLE    = (NUM == 1);

    rd_state_t state_q, state_d;

    logic [ADDR_W-1:0]     base_q;
    logic [ADDR_W-1:0]     n_q;
    logic [ADDR_W-1:0]     base_c;
    logic                  rd_p1_q, rd_p1_last_q;
    logic                  rd_p2_q, rd_p2_last_q;
    logic [FIFO_CNT_W-1:0] inflight_c;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_empty;
    logic [WIDTH:0]        fifo_head;
    logic                  credit_ok_c;
    logic                  accept_c, reject_c, issue_c, finish_c;
    logic                  pop_c;

    assign base_c      = t_idx * NUM_A;
    assign inflight_c  = FIFO_CNT_W'(rd_p1_q) + FIFO_CNT_W'(rd_p2_q);
    // Same-cycle pop is deliberately ignored: conservative, still full rate
    assign credit_ok_c = (fifo_count + inflight_c) < FIFO_CNT_W'(FIFO_DEPTH);

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_head[WIDTH-1:0];
    assign m_last  = fifo_head[WIDTH];
    assign pop_c   = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle action decode
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        reject_c = 1'b0;
        issue_c  = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ({1'b0, t_idx} < T_LIMIT) begin
                        accept_c = 1'b1;
                        state_d  = SINGLE ? DRAIN : STREAM;
                    end else begin
                        reject_c = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (credit_ok_c && (n_q <= LAST_N)) begin
                    issue_c = 1'b1;
                    if (n_q == LAST_N) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_c && m_last) begin
                    finish_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address walk, status pulses and the two-stage read-latency tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            n_q          <= '0;
            addr_b       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            rd_p1_q      <= 1'b0;
            rd_p1_last_q <= 1'b0;
            rd_p2_q      <= 1'b0;
            rd_p2_last_q <= 1'b0;
        end else begin
            done <= finish_c;
            err  <= reject_c;
            if (accept_c) begin
                base_q <= base_c;
                addr_b <= base_c;
                n_q    <= ADDR_W'(1);
                busy   <= 1'b1;
            end else if (issue_c) begin
                addr_b <= base_q + n_q;
                n_q    <= n_q + ADDR_W'(1);
            end
            if (finish_c) begin
                busy <= 1'b0;
            end
            rd_p1_q      <= accept_c || issue_c;
            rd_p1_last_q <= (accept_c && SINGLE) || (issue_c && (n_q == LAST_N));
            rd_p2_q      <= rd_p1_q;
            rd_p2_last_q <= rd_p1_last_q;
        end
    end

    act_fifo #(
        .W (WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_p2_q),
        .din   ({rd_p2_last_q, o_b}),
        .pop   (pop_c),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_act_stream_reader.sv
// Scoreboard bench for act_stream_reader: directed starts push expected beats,
// a negedge monitor pops and compares every stream handshake.
module tb_act_stream_reader;
    import lstm_defs_pkg::*;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned NUM      = 53;
    localparam int unsigned TIMESTEP = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] t_idx;
    logic              busy, done, err;
    logic [ADDR_W-1:0] addr_b;
    logic [WIDTH-1:0]  o_b;
    logic [WIDTH-1:0]  m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic              m_last;

    logic [WIDTH-1:0] mem [4096];
    int               checks = 0;
    int               errors = 0;
    int               ready_mode = 1;
    int               beats = 0;
    beat_t            exp_q[$];
    beat_t            e;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    act_stream_reader #(
        .WIDTH    (WIDTH),
        .NUM      (NUM),
        .TIMESTEP (TIMESTEP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .t_idx   (t_idx),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .addr_b  (addr_b),
        .o_b     (o_b),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model, one cycle latency
    always @(posedge clk) o_b <= mem[addr_b];

    // Consumer ready: 0 = stalled, 1 = always ready, 2 = ~30% duty random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 99) < 30);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int t);
        start = 1'b1;
        t_idx = ADDR_W'(t);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_exp(input int base);
        beat_t b;
        for (int i = 0; i < NUM; i++) begin
            b.data = 32'(base + i);
            b.last = (i == NUM - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", name, max_cyc);
        end
    endtask

    // Monitor: stall stability, FIFO bound and scoreboard pop on each handshake
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (m_valid) begin
                check("fifo_bound", 32'(dut.u_fifo.count_q <= 3'd4), 32'd1);
                if (prev_stall) begin
                    check("stall_data", m_data, prev_data);
                    check("stall_last", 32'(m_last), 32'(prev_last));
                end
                if (m_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0d, expected no beat", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_data, e.data);
                        check("beat_last", 32'(m_last), 32'(e.last));
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
        rst   = 1'b1;
        start = 1'b0;
        t_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_addr_b", 32'(addr_b), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_m_data", m_data, 0);
        rst = 1'b0;
        tick();

        // Full-rate stream of timestep 2
        ready_mode = 1;
        push_exp(2 * NUM);
        do_start(2);
        check("a_busy", 32'(busy), 1);
        check("a_addr_first", 32'(addr_b), 106);
        tick();
        check("a_valid_e1", 32'(m_valid), 0);
        for (int k = 0; k < NUM; k++) begin
            tick();
            check("a_valid_run", 32'(m_valid), 1);
            check("a_last_flag", 32'(m_last), 32'(k == NUM - 1));
        end
        tick();
        check("a_done", 32'(done), 1);
        check("a_busy_fall", 32'(busy), 0);
        check("a_valid_end", 32'(m_valid), 0);
        tick();
        check("a_done_pulse", 32'(done), 0);
        check("a_queue_empty", 32'(exp_q.size()), 0);

        // Random backpressure
        ready_mode = 2;
        beats = 0;
        push_exp(2 * NUM);
        do_start(2);
        wait_done(2000, "b_done");
        check("b_beats", 32'(beats), NUM);
        check("b_queue_empty", 32'(exp_q.size()), 0);
        ready_mode = 1;
        tick();

        // Out-of-range timestep
        do_start(4);
        check("c_err", 32'(err), 1);
        check("c_busy", 32'(busy), 0);
        check("c_addr_hold", 32'(addr_b), 158);
        tick();
        check("c_err_pulse", 32'(err), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("c_no_valid", 32'(m_valid | busy), 0);
        end

        // Reset mid-transfer, then restart at timestep 0
        push_exp(NUM);
        do_start(1);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("d_busy", 32'(busy), 0);
        check("d_valid", 32'(m_valid), 0);
        check("d_addr", 32'(addr_b), 0);
        check("d_data", m_data, 0);
        check("d_flags", 32'({done, err, m_last}), 0);
        repeat (3) tick();
        check("d_quiet", 32'(m_valid), 0);
        push_exp(0);
        do_start(0);
        wait_done(200, "d_done");
        check("d_queue_empty", 32'(exp_q.size()), 0);

        // Ignored mid-transfer start, then back-to-back start on done cycle
        tick();
        push_exp(3 * NUM);
        do_start(3);
        repeat (20) tick();
        do_start(0);
        check("e_no_err", 32'(err), 0);
        check("e_still_busy", 32'(busy), 1);
        wait_done(200, "e_done1");
        check("e_q1_empty", 32'(exp_q.size()), 0);
        push_exp(NUM);
        do_start(1);
        check("e2_busy", 32'(busy), 1);
        check("e2_addr", 32'(addr_b), 53);
        check("e2_valid_e0", 32'(m_valid), 0);
        tick();
        check("e2_valid_e1", 32'(m_valid), 0);
        tick();
        check("e2_valid_e2", 32'(m_valid), 1);
        check("e2_first_data", m_data, 53);
        wait_done(200, "e_done2");
        check("e_q2_empty", 32'(exp_q.size()), 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
